// File: rtl/mem_pkg.sv
// Shared encodings for the load/store controller in front of the 16-bit data memory.
package mem_pkg;

   localparam logic [1:0] OP_LW = 2'b00;
   localparam logic [1:0] OP_LB = 2'b01;
   localparam logic [1:0] OP_SW = 2'b10;
   localparam logic [1:0] OP_SB = 2'b11;

   localparam logic [1:0] MEMW_NONE = 2'b00;
   localparam logic [1:0] MEMW_BYTE = 2'b01;
   localparam logic [1:0] MEMW_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_RESP   = 2'b10
   } state_e;

   function automatic logic is_store(input logic [1:0] op);
      return op[1];
   endfunction

   // Write-enable pattern the memory expects for a given store op.
   function automatic logic [1:0] store_memw(input logic [1:0] op);
      logic [1:0] w;
      case (op)
         OP_SW:   w = MEMW_WORD;
         OP_SB:   w = MEMW_BYTE;
         default: w = MEMW_NONE;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Shapes the memory read outputs into the 16-bit load result (word, or byte with sign/zero extension).
module load_extend
   import mem_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic        sign_i,
   input  logic [15:0] word_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] result_o
);

   always_comb begin
      result_o = 16'h0000;
      case (op_i)
         OP_LW:   result_o = word_i;
         OP_LB:   result_o = {{8{byte_i[7] & sign_i}}, byte_i};
         default: result_o = 16'h0000;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: latches a request, holds the address for
// WAIT_CYCLES, strobes or samples the memory, then holds the response until consumed.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int MEM_DEPTH   = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wword,
   output logic [7:0]  mem_wbyte,
   output logic [1:0]  mem_memw,
   input  logic [15:0] mem_word,
   input  logic [7:0]  mem_byte
);

   localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
   localparam logic [16:0] DEPTH_L  = 17'(MEM_DEPTH);

   state_e      state_q;
   logic [1:0]  op_q;
   logic        signed_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [3:0]  cnt_q;
   logic [15:0] rsp_data_q;
   logic        rsp_err_q;

   logic        addr_ok_s;
   logic        final_s;
   logic [15:0] ext_s;
   logic [1:0]  memw_d;

   assign addr_ok_s = ({1'b0, req_addr} < DEPTH_L);
   assign final_s   = (state_q == S_ACCESS) && (cnt_q == 4'h0);

   load_extend u_load_extend (
      .op_i     (op_q),
      .sign_i   (signed_q),
      .word_i   (mem_word),
      .byte_i   (mem_byte),
      .result_o (ext_s)
   );

   // Request/access/response sequencing with all response fields registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_LW;
         signed_q   <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 16'h0000;
         cnt_q      <= 4'h0;
         rsp_data_q <= 16'h0000;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  signed_q   <= req_signed;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  cnt_q      <= CNT_INIT;
                  rsp_data_q <= 16'h0000;
                  if (addr_ok_s) begin
                     state_q   <= S_ACCESS;
                     rsp_err_q <= 1'b0;
                  end else begin
                     state_q   <= S_RESP;
                     rsp_err_q <= 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt_q == 4'h0) begin
                  state_q    <= S_RESP;
                  rsp_err_q  <= 1'b0;
                  rsp_data_q <= is_store(op_q) ? 16'h0000 : ext_s;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Write strobe is gated by reset so a reset landing on the strobe cycle never writes.
   always_comb begin
      memw_d = MEMW_NONE;
      if (rst && final_s && is_store(op_q)) begin
         memw_d = store_memw(op_q);
      end else begin
         memw_d = MEMW_NONE;
      end
   end

   assign mem_memw  = memw_d;
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = addr_q;
   assign mem_wword = wdata_q;
   assign mem_wbyte = wdata_q[7:0];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance at WAIT_CYCLES=1 with a queue-driven
// response monitor, and one at WAIT_CYCLES=3 for strobe timing and reset-on-strobe.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_valid3 = 1'b0;
   logic [1:0]  req_op = 2'b00;
   logic        req_signed = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [15:0] req_wdata = 16'h0000;
   logic        rsp_ready = 1'b1, rsp_ready3 = 1'b1;

   logic        req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_data, mem_addr, mem_wword, mem_word;
   logic [7:0]  mem_wbyte, mem_byte;
   logic [1:0]  mem_memw;

   logic        req_ready3, rsp_valid3, rsp_err3;
   logic [15:0] rsp_data3, mem_addr3, mem_wword3, mem_word3;
   logic [7:0]  mem_wbyte3, mem_byte3;
   logic [1:0]  mem_memw3;

   logic [15:0] mema [0:15];
   logic [15:0] mem3 [0:15];

   logic [16:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          pulses = 0;
   logic [15:0] last_paddr = 16'h0000;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wword(mem_wword), .mem_wbyte(mem_wbyte), .mem_memw(mem_memw),
      .mem_word(mem_word), .mem_byte(mem_byte)
   );

   mem_access_ctrl #(.WAIT_CYCLES(3), .MEM_DEPTH(16)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_op(req_op), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
      .mem_addr(mem_addr3), .mem_wword(mem_wword3), .mem_wbyte(mem_wbyte3), .mem_memw(mem_memw3),
      .mem_word(mem_word3), .mem_byte(mem_byte3)
   );

   // Behavioural 16-word memory: combinational read, write on the rising edge per MemW.
   assign mem_word  = (mem_addr < 16'd16) ? mema[mem_addr[3:0]] : 16'h0000;
   assign mem_byte  = mem_word[7:0];
   assign mem_word3 = (mem_addr3 < 16'd16) ? mem3[mem_addr3[3:0]] : 16'h0000;
   assign mem_byte3 = mem_word3[7:0];

   always @(posedge clk) begin
      if (mem_addr < 16'd16) begin
         if (mem_memw == 2'b10) mema[mem_addr[3:0]] <= mem_wword;
         else if (mem_memw == 2'b01) mema[mem_addr[3:0]][7:0] <= mem_wbyte;
      end
      if (mem_addr3 < 16'd16) begin
         if (mem_memw3 == 2'b10) mem3[mem_addr3[3:0]] <= mem_wword3;
         else if (mem_memw3 == 2'b01) mem3[mem_addr3[3:0]][7:0] <= mem_wbyte3;
      end
   end

   // Count write strobes on the main instance.
   always @(negedge clk) begin
      if (mem_memw != 2'b00) begin
         pulses     = pulses + 1;
         last_paddr = mem_addr;
      end
   end

   // Response monitor: pops the expected {err,data} on every completed response handshake.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL rsp_unexpected: got err=%0b data=%h, required no response", rsp_err, rsp_data);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({rsp_err, rsp_data} !== e) begin
               fails = fails + 1;
               $display("FAIL rsp_data: got err=%0b data=%h, required err=%0b data=%h",
                        rsp_err, rsp_data, e[16], e[15:0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic sgn, input logic [15:0] addr,
                       input logic [15:0] wd, input logic err, input logic [15:0] exp_d);
      bit done = 1'b0;
      @(posedge clk); #1;
      req_op = op; req_signed = sgn; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            exp_q.push_back({err, exp_d});
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      req_valid = 1'b0;
      if (!done) chk("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send3(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
      bit done = 1'b0;
      @(posedge clk); #1;
      req_op = op; req_signed = 1'b0; req_addr = addr; req_wdata = wd; req_valid3 = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (req_ready3) begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      req_valid3 = 1'b0;
      if (!done) chk("req3_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      // Reset and idle state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("memw_in_reset", 32'(mem_memw), 32'd0);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_memw", 32'(mem_memw), 32'd0);

      // Store word then load it back, with cycle-exact strobe timing
      p0 = pulses;
      send(2'b10, 1'b0, 16'd3, 16'hBEEF, 1'b0, 16'h0000);
      @(negedge clk);
      chk("sw_memw_word", 32'(mem_memw), 32'h2);
      chk("sw_mem_addr", 32'(mem_addr), 32'd3);
      chk("sw_rsp_not_yet", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("sw_memw_after", 32'(mem_memw), 32'd0);
      drain();
      chk("sw_one_pulse", 32'(pulses - p0), 32'd1);
      send(2'b00, 1'b0, 16'd3, 16'h0000, 1'b0, 16'hBEEF);

      // Byte store over an existing word and the three load flavours
      send(2'b10, 1'b0, 16'd5, 16'hAB00, 1'b0, 16'h0000);
      send(2'b11, 1'b0, 16'd5, 16'h1280, 1'b0, 16'h0000);
      send(2'b01, 1'b1, 16'd5, 16'h0000, 1'b0, 16'hFF80);
      send(2'b01, 1'b0, 16'd5, 16'h0000, 1'b0, 16'h0080);
      send(2'b00, 1'b0, 16'd5, 16'h0000, 1'b0, 16'hAB80);
      drain();

      // Out-of-range addresses
      p0 = pulses;
      send(2'b10, 1'b0, 16'd16, 16'h5555, 1'b1, 16'h0000);
      @(negedge clk);
      chk("oor16_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("oor16_rsp_err", 32'(rsp_err), 32'd1);
      drain();
      send(2'b11, 1'b0, 16'hFFFF, 16'h00AA, 1'b1, 16'h0000);
      drain();
      chk("oor_no_pulse", 32'(pulses - p0), 32'd0);

      // Response backpressure with a competing request held pending
      rsp_ready = 1'b0;
      send(2'b00, 1'b0, 16'd3, 16'h0000, 1'b0, 16'hBEEF);
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      p0 = pulses;
      req_op = 2'b10; req_addr = 16'd7; req_wdata = 16'h1111; req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_data", 32'(rsp_data), 32'hBEEF);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1; rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_turnaround", 32'(req_ready), 32'd0);
      exp_q.push_back({1'b0, 16'h0000});
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready_after", 32'(req_ready), 32'd1);
      @(posedge clk); #1; req_valid = 1'b0;
      drain();
      chk("bp_one_pulse", 32'(pulses - p0), 32'd1);
      chk("bp_pulse_addr", 32'(last_paddr), 32'd7);
      send(2'b00, 1'b0, 16'd7, 16'h0000, 1'b0, 16'h1111);
      drain();

      // WAIT_CYCLES=3: strobe in the third access cycle, then reset on the strobe cycle
      send3(2'b10, 16'd2, 16'h1234);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("w3_memw_timing", 32'(mem_memw3), (c == 3) ? 32'h2 : 32'h0);
      end
      @(negedge clk);
      chk("w3_rsp_valid", 32'(rsp_valid3), 32'd1);
      chk("w3_rsp_data", 32'(rsp_data3), 32'd0);
      chk("w3_mem_written", 32'(mem3[2]), 32'h1234);
      send3(2'b10, 16'd2, 16'h5678);
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_strobe_memw", 32'(mem_memw3), 32'd0);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("rst_strobe_idle", 32'(req_ready3), 32'd1);
      chk("rst_strobe_no_rsp", 32'(rsp_valid3), 32'd0);
      chk("rst_strobe_mem", 32'(mem3[2]), 32'h1234);
      send3(2'b00, 16'd2, 16'h0000);
      for (int i = 0; i < 20 && !rsp_valid3; i++) @(negedge clk);
      chk("w3_load_valid", 32'(rsp_valid3), 32'd1);
      chk("w3_load_data", 32'(rsp_data3), 32'h1234);

      repeat (2) @(posedge clk);
      chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store controller directly upstream of the 16-bit data memory.
- Accepts one load or store request at a time from the datapath over a valid/ready handshake.
- Drives the memory's address, write-data and 2-bit write-enable (MemW) inputs, and captures the combinational Byte/Word read outputs.
- Returns extended load data or a store acknowledge over a valid/ready response channel.

Parameters:
WAIT_CYCLES, 1, number of cycles the address is held before the load sample or store strobe; legal range 1..15.
MEM_DEPTH, 16, number of memory words; any address >= MEM_DEPTH is out of range.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous active-low reset, sampled on the rising edge of clk
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 load word, 01 load byte, 10 store word, 11 store byte
req_signed  in  1  load byte: 1 sign-extends, 0 zero-extends
req_addr  in  16  word address
req_wdata  in  16  store data; byte stores use bits [7:0]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  16  load result; 0 for stores and errors
rsp_err  out  1  address was out of range
mem_addr  out  16  to memory Addr
mem_wword  out  16  to memory WriteW
mem_wbyte  out  8  to memory WriteB
mem_memw  out  2  to memory MemW: 10 word write, 01 byte write, 00 none
mem_word  in  16  from memory Word
mem_byte  in  8  from memory Byte

Behaviour:
Reset (rst=0 at a clock edge):
- State goes to IDLE; all registered outputs clear to 0; wait counter clears.
- mem_memw is gated combinationally by rst, so it is 00 during any cycle in which rst=0. No write can occur in a reset cycle, including a reset that lands in the strobe cycle.

FSM states: IDLE, ACCESS, RESP.

IDLE:
- req_ready=1.
- On req_valid=1, latch op, signed, addr and wdata. Set counter to WAIT_CYCLES-1.
- Go to ACCESS if addr < MEM_DEPTH.
- Otherwise go to RESP with rsp_err=1 and rsp_data=0. No memory strobe is issued.

ACCESS:
- req_ready=0. mem_addr is the latched address; mem_wword and mem_wbyte are the latched data.
- Counter decrements each cycle.
- Final cycle (counter==0):
  - Store: mem_memw=10 for a word store, 01 for a byte store, for exactly this cycle. rsp_data is set to 0.
  - Load word: rsp_data is registered from mem_word.
  - Load byte: rsp_data is registered from {8{mem_byte[7]&signed}, mem_byte}.
  - Then go to RESP.
- mem_memw=00 in every other cycle and state.

RESP:
- rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready=1.
- On rsp_ready=1, return to IDLE. The next request can be accepted on the following cycle; there is no same-cycle turnaround.

Timing and other rules:
- Latency: a request accepted at edge T gives its final ACCESS cycle at T+WAIT_CYCLES and rsp_valid=1 starting at T+WAIT_CYCLES+1.
- rsp_ready=1 while rsp_valid=0 has no effect.
- req_valid while req_ready=0 is ignored. The requester holds the request until accepted.
- mem_addr keeps the last latched address in IDLE (0 after reset). mem_memw=00 in IDLE.
- Addresses are unsigned 16-bit values; address 0xFFFF is out of range.
- The counter is 4 bits and never wraps because WAIT_CYCLES <= 15.

Decomposition:
- Shared package mem_pkg holds:
  - op encodings: OP_LW=2'b00, OP_LB=2'b01, OP_SW=2'b10, OP_SB=2'b11;
  - MemW encodings: MEMW_NONE=2'b00, MEMW_BYTE=2'b01, MEMW_WORD=2'b10;
  - state encodings: S_IDLE, S_ACCESS, S_RESP.
- One combinational sub-module, load_extend: inputs op, signed, word and byte; output the 16-bit result.

Test Plan:
1. Reset then idle → all outputs 0, mem_memw=00, req_ready=1.
2. Store word, addr 3, data 16'hBEEF, WAIT_CYCLES=1 → mem_memw=10 for exactly one cycle with mem_addr=3; rsp_valid next cycle, rsp_data=0, rsp_err=0. Then load word at addr 3 → rsp_data=16'hBEEF.
3. Store byte, addr 5, data 16'h1280, over an existing word 16'hAB00; then load byte:
   - signed → rsp_data=16'hFF80;
   - unsigned → 16'h0080;
   - load word → 16'hAB80.
4. Addr 16 or 16'hFFFF with a store → no mem_memw pulse; rsp_err=1 and rsp_data=0 one cycle after acceptance.
5. Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable throughout; req_ready=0; a new req_valid is ignored until one cycle after rsp_ready=1.
6. rst=0 in the strobe cycle of a store with WAIT_CYCLES=3 → mem_memw=00, memory unchanged, controller in IDLE next cycle.
